// File: rtl/instr_word_writer.sv
// instr_word_writer
//   Writer side of the instruction-memory interface. Takes decoded RISC-V
//   fields (R/I/S/SB/UJ) over a valid/ready handshake, packs them into 32-bit
//   instruction words and writes them to consecutive word addresses starting at
//   a programmable base address.
//
//   Optional feature: define INSTR_READBACK_CHECK_EN to read back each word
//   after writing it and compare it (adds the err_verify port).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           1-cycle pulse: load base address, clear count and errors
//   i_base_addr       first write byte address
//   i_in_valid        field bundle valid
//   o_in_ready        block can accept a bundle
//   i_fmt             0=R 1=I 2=S 3=SB 4=UJ, 5..7 illegal
//   i_op              opcode
//   i_rd, i_rs1, i_rs2, i_f3, i_f7
//                     instruction fields
//   i_imm             raw immediate
//   o_mem_addr        memory address
//   o_mem_wdata       encoded word
//   o_mem_write       write strobe (one cycle per word)
//   o_mem_read        read strobe (readback only)
//   i_mem_rdata       memory read data (readback only)
//   o_word_count      words written since start
//   o_full            word_count == MAX_WORDS
//   o_err_fmt         sticky: illegal fmt received
//   o_err_align       sticky: misaligned base at start
//   o_err_verify      sticky: readback mismatch (readback build only)
module instr_word_writer #(
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_fmt,
    input  logic [6:0]       i_op,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [2:0]       i_f3,
    input  logic [6:0]       i_f7,
    input  logic [31:0]      i_imm,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic             o_mem_write,
    output logic             o_mem_read,
    input  logic [31:0]      i_mem_rdata,
    output logic [CNT_W-1:0] o_word_count,
    output logic             o_full,
    output logic             o_err_fmt,
    output logic             o_err_align
`ifdef INSTR_READBACK_CHECK_EN
    ,
    output logic             o_err_verify
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_addr;      // address the next accepted word goes to
    logic [31:0]       r_mem_addr;  // address of the word being written/read
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_count;
    logic              r_err_fmt;
    logic              r_err_align;
    logic [31:0]       w_word;
    logic              w_fmt_ok;
    logic              w_full;
    logic              w_hs;

    assign w_full = (r_count == CNT_W'(MAX_WORDS));
    assign w_hs   = i_in_valid & o_in_ready;

    // Field packing; only the immediate bits each format uses are taken.
    always_comb begin
        w_word   = '0;
        w_fmt_ok = 1'b1;
        case (i_fmt)
            3'd0: w_word = {i_f7, i_rs2, i_rs1, i_f3, i_rd, i_op};
            3'd1: w_word = {i_imm[11:0], i_rs1, i_f3, i_rd, i_op};
            3'd2: w_word = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], i_op};
            3'd3: w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3,
                            i_imm[4:1], i_imm[11], i_op};
            3'd4: w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                            i_rd, i_op};
            default: w_fmt_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state. A start lets a WRITE in flight finish its cycle but drops
    // any readback that would follow it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hs && w_fmt_ok) w_next = S_WRITE;
`ifdef INSTR_READBACK_CHECK_EN
            S_WRITE: w_next = S_READ;
            S_READ:  w_next = S_CHECK;
            S_CHECK: w_next = S_IDLE;
`else
            S_WRITE: w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
        if (i_start && r_state != S_IDLE) w_next = S_IDLE;
    end

    // Outputs. mem_write comes straight from the state so an async reset
    // removes it immediately.
    always_comb begin
        o_in_ready  = (r_state == S_IDLE) & ~w_full & ~r_err_align & ~i_start;
        o_mem_write = (r_state == S_WRITE);
`ifdef INSTR_READBACK_CHECK_EN
        o_mem_read  = (r_state == S_READ);
`else
        o_mem_read  = 1'b0;
`endif
    end

    // Datapath: address, word, count, sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_count     <= '0;
            r_err_fmt   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            if (w_hs && w_fmt_ok) begin
                r_mem_addr <= r_addr;
                r_wdata    <= w_word;
            end
            if (w_hs && !w_fmt_ok) r_err_fmt <= 1'b1;
            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + 1'b1;
            end
            // start has the last word: it overrides the WRITE-end advance
            if (i_start) begin
                r_addr      <= i_base_addr;
                r_mem_addr  <= i_base_addr;
                r_count     <= '0;
                r_err_fmt   <= 1'b0;
                r_err_align <= |i_base_addr[1:0];
            end
        end
    end

`ifdef INSTR_READBACK_CHECK_EN
    logic r_err_verify;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_err_verify <= 1'b0;
        else if (i_start) r_err_verify <= 1'b0;
        else if (r_state == S_CHECK && i_mem_rdata != r_wdata)
            r_err_verify <= 1'b1;
    end
    assign o_err_verify = r_err_verify;

    logic w_unused;
    assign w_unused = ^i_imm[31:21];
`else
    logic w_unused;
    assign w_unused = ^{i_imm[31:21], i_mem_rdata};
`endif

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_word_count = r_count;
    assign o_full       = w_full;
    assign o_err_fmt    = r_err_fmt;
    assign o_err_align  = r_err_align;

endmodule
